// File: rtl/traffic_ctrl_n_if.sv
// Sensor/parade inputs and lamp/status outputs of the N-approach traffic controller.
// master: sensor/stimulus side; slave: controller side.
interface traffic_ctrl_n_if #(
    parameter int NUM_DIRS = 4
) ();
    localparam int DIR_W = $clog2(NUM_DIRS);

    logic                  p;
    logic                  r;
    logic [NUM_DIRS-1:0]   t;
    logic [2*NUM_DIRS-1:0] lights;
    logic [DIR_W-1:0]      cur_dir;
    logic                  parade;

    modport master (output p, r, t, input lights, cur_dir, parade);
    modport slave  (input p, r, t, output lights, cur_dir, parade);
endinterface

// File: rtl/traffic_ctrl_n.sv
// N-approach round-robin traffic-light controller with parade mode.
// Define TLC_ALLRED_EN to insert an all-red clearance phase between yellow and the next green.
module traffic_ctrl_n #(
    parameter int NUM_DIRS      = 4,
    parameter int MIN_GREEN     = 5,
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_CYCLES = 2,
    parameter int PARADE_DIR    = 1
) (
    input  logic             clk,
    input  logic             reset,
    traffic_ctrl_n_if.slave  bus
);
    localparam int DIR_W = $clog2(NUM_DIRS);
    localparam int MAX_A = (MIN_GREEN > YELLOW_CYCLES) ? MIN_GREEN : YELLOW_CYCLES;
    localparam int MAX_C = (MAX_A > ALLRED_CYCLES) ? MAX_A : ALLRED_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);
    localparam logic [2*NUM_DIRS-1:0] RESET_LIGHTS = {{(NUM_DIRS-1){2'b10}}, 2'b00};

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1
`ifdef TLC_ALLRED_EN
        ,S_ALLRED = 2'd2
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIR_W-1:0]      cur_dir_q, cur_dir_d;
    logic [DIR_W-1:0]      next_dir_q, next_dir_d;
    logic                  parade_q, parade_d;
    logic [2*NUM_DIRS-1:0] lights_q, lights_d;

    logic                  found;
    logic [DIR_W-1:0]      rr_dir;
    logic [DIR_W-1:0]      cand;

    // Round-robin search starting after cur_dir; cur_dir itself is never a candidate.
    always_comb begin
        found  = 1'b0;
        rr_dir = cur_dir_q;
        cand   = cur_dir_q;
        for (int i = 1; i < NUM_DIRS; i++) begin
            if (int'(cur_dir_q) + i >= NUM_DIRS) cand = DIR_W'(int'(cur_dir_q) + i - NUM_DIRS);
            else                                  cand = DIR_W'(int'(cur_dir_q) + i);
            if (!found && bus.t[cand]) begin
                found  = 1'b1;
                rr_dir = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_dir_d  = cur_dir_q;
        next_dir_d = next_dir_q;
        parade_d   = parade_q;
        lights_d   = {NUM_DIRS{2'b10}};

        if (bus.r)      parade_d = 1'b0;
        else if (bus.p) parade_d = 1'b1;

        case (state_q)
            S_GREEN: begin
                if (cnt_q != CNT_W'(MIN_GREEN - 1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (parade_q) begin
                    if (cur_dir_q != DIR_W'(PARADE_DIR)) begin
                        state_d    = S_YELLOW;
                        cnt_d      = '0;
                        next_dir_d = DIR_W'(PARADE_DIR);
                    end
                end else if (!bus.t[cur_dir_q] && found) begin
                    state_d    = S_YELLOW;
                    cnt_d      = '0;
                    next_dir_d = rr_dir;
                end
            end
            S_YELLOW: begin
                if (cnt_q == CNT_W'(YELLOW_CYCLES - 1)) begin
                    cnt_d = '0;
`ifdef TLC_ALLRED_EN
                    state_d = S_ALLRED;
`else
                    state_d   = S_GREEN;
                    cur_dir_d = next_dir_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef TLC_ALLRED_EN
            S_ALLRED: begin
                if (cnt_q == CNT_W'(ALLRED_CYCLES - 1)) begin
                    cnt_d     = '0;
                    state_d   = S_GREEN;
                    cur_dir_d = next_dir_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = S_GREEN;
                cnt_d   = '0;
            end
        endcase

        // Lamps are computed from the next state so they register together with it.
        for (int i = 0; i < NUM_DIRS; i++) begin
            if (cur_dir_d == DIR_W'(i)) begin
                if (state_d == S_GREEN)       lights_d[2*i +: 2] = 2'b00;
                else if (state_d == S_YELLOW) lights_d[2*i +: 2] = 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_GREEN;
            cnt_q      <= '0;
            cur_dir_q  <= '0;
            next_dir_q <= '0;
            parade_q   <= 1'b0;
            lights_q   <= RESET_LIGHTS;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_dir_q  <= cur_dir_d;
            next_dir_q <= next_dir_d;
            parade_q   <= parade_d;
            lights_q   <= lights_d;
        end
    end

    assign bus.lights  = lights_q;
    assign bus.cur_dir = cur_dir_q;
    assign bus.parade  = parade_q;
endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Directed bench for traffic_ctrl_n (4 approaches, default timing); adapts to TLC_ALLRED_EN.
module tb_traffic_ctrl_n;
    localparam int G = 5;
    localparam int Y = 3;
`ifdef TLC_ALLRED_EN
    localparam int AR = 2;
`else
    localparam int AR = 0;
`endif
    // Lamp words written dir3..dir0
    localparam logic [7:0] L_D0G = 8'hA8;  // 10_10_10_00
    localparam logic [7:0] L_D0Y = 8'hA9;  // 10_10_10_01
    localparam logic [7:0] L_ALR = 8'hAA;  // 10_10_10_10
    localparam logic [7:0] L_D1G = 8'hA2;  // 10_10_00_10
    localparam logic [7:0] L_D1Y = 8'hA6;  // 10_10_01_10
    localparam logic [7:0] L_D2G = 8'h8A;  // 10_00_10_10
    localparam logic [7:0] L_D2Y = 8'h9A;  // 10_01_10_10

    logic clk = 1'b0;
    logic reset;
    int   nchk = 0;
    int   nfail = 0;

    traffic_ctrl_n_if #(.NUM_DIRS(4)) bus ();

    traffic_ctrl_n #(
        .NUM_DIRS(4), .MIN_GREEN(5), .YELLOW_CYCLES(3), .ALLRED_CYCLES(2), .PARADE_DIR(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] l, input logic [1:0] d, input logic pa);
        chk({tag, ".lights"},  32'(bus.lights),  32'(l));
        chk({tag, ".cur_dir"}, 32'(bus.cur_dir), 32'(d));
        chk({tag, ".parade"},  32'(bus.parade),  32'(pa));
    endtask

    // Remaining green cycles, then yellow, optional all-red, then the new green.
    task automatic phase(input string tag, input int gsteps, input logic [7:0] grn,
                         input logic [7:0] yel, input logic [1:0] od,
                         input logic [7:0] ngrn, input logic [1:0] nd, input logic pa);
        for (int k = 0; k < gsteps; k++) begin step(); chk_all({tag, ".green"}, grn, od, pa); end
        for (int k = 0; k < Y; k++)      begin step(); chk_all({tag, ".yellow"}, yel, od, pa); end
        for (int k = 0; k < AR; k++)     begin step(); chk_all({tag, ".allred"}, L_ALR, od, pa); end
        step();
        chk_all({tag, ".newgreen"}, ngrn, nd, pa);
    endtask

    initial begin
        // Reset with random inputs
        reset = 1'b1;
        bus.t = 4'($urandom);
        bus.p = 1'($urandom);
        bus.r = 1'($urandom);
        step();
        chk_all("reset1", L_D0G, 2'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            bus.t = 4'($urandom);
            bus.p = 1'($urandom);
            bus.r = 1'($urandom);
            step();
        end
        chk_all("reset3", L_D0G, 2'd0, 1'b0);

        // Idle: no traffic, dir0 keeps green
        bus.t = 4'b0000; bus.p = 1'b0; bus.r = 1'b0;
        step();
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            chk_all("idle", L_D0G, 2'd0, 1'b0);
        end

        // Mid-yellow reset, with parade set beforehand
        reset = 1'b1; bus.t = 4'b0100;
        step();
        reset = 1'b0; bus.p = 1'b1;
        step();
        bus.p = 1'b0;
        chk_all("myr.pset", L_D0G, 2'd0, 1'b1);
        for (int k = 0; k < 5; k++) step();
        chk_all("myr.yellow", L_D0Y, 2'd0, 1'b1);
        reset = 1'b1;
        step();
        chk_all("myr.reset", L_D0G, 2'd0, 1'b0);

        // Single request for dir2 from reset release
        bus.t = 4'b0100;
        step();
        reset = 1'b0;
        phase("single", G - 1, L_D0G, L_D0Y, 2'd0, L_D2G, 2'd2, 1'b0);

        // Round-robin wrap: from dir2, t=0011 goes to dir0, then dir1 after t[0] drops
        bus.t = 4'b0011;
        phase("wrap", G - 1, L_D2G, L_D2Y, 2'd2, L_D0G, 2'd0, 1'b0);
        bus.t = 4'b0010;
        phase("rr1", G - 1, L_D0G, L_D0Y, 2'd0, L_D1G, 2'd1, 1'b0);

        // Parade: pulse p while dir0 green with its own traffic
        reset = 1'b1; bus.t = 4'b0001;
        step();
        reset = 1'b0; bus.p = 1'b1;
        step();
        bus.p = 1'b0;
        chk_all("parade.set", L_D0G, 2'd0, 1'b1);
        phase("parade.go", G - 2, L_D0G, L_D0Y, 2'd0, L_D1G, 2'd1, 1'b1);
        bus.t = 4'b1101;
        for (int k = 0; k < 40; k++) begin
            step();
            chk_all("parade.hold", L_D1G, 2'd1, 1'b1);
        end
        bus.r = 1'b1;
        step();
        bus.r = 1'b0;
        chk_all("parade.rel", L_D1G, 2'd1, 1'b0);
        phase("parade.exit", 0, L_D1G, L_D1Y, 2'd1, L_D2G, 2'd2, 1'b0);

        // p and r together: release wins
        bus.p = 1'b1; bus.r = 1'b1;
        step();
        chk("conflict.from0", 32'(bus.parade), 32'd0);
        bus.r = 1'b0;
        step();
        chk("conflict.pset", 32'(bus.parade), 32'd1);
        bus.r = 1'b1;
        step();
        chk("conflict.from1", 32'(bus.parade), 32'd0);
        bus.p = 1'b0; bus.r = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end
endmodule
